booth_mult_sched: RTL and testbench

- Controller and arbiter that shares one iterative radix-2 Booth multiplier datapath (16-bit, one Booth step per clock) among N_REQ requesters.
- Arbitrates requests round-robin, loads operands, issues exactly ITERS step pulses, captures the 16-bit low product and returns it with the requester ID.
- Sits between ALU-side clients and the multiplier core; the core itself holds no sequencing logic.

---
 rtl/booth_mult_sched_pkg.sv | 28 ++
 rtl/booth_rr_arbiter.sv | 42 ++++
 rtl/booth_mult_sched.sv | 156 +++++++++++++++
 tb/tb_booth_mult_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_sched_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_sched_pkg
// Shared definitions for the Booth multiplier scheduler:
//   - controller FSM state encoding
//   - default requester count, operand width and iteration count
//   - requester ID width derivation
// No ports (package).
// -----------------------------------------------------------------------------
package booth_mult_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 16;
  localparam int ITERS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // A single requester still needs a one-bit ID field so the ports stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_rr_arbiter.sv
// -----------------------------------------------------------------------------
// booth_rr_arbiter
// Purely combinational round-robin select. Searches i_req starting at index
// i_rr_ptr and moving upward with wrap-around; the first asserted bit wins.
// Ports:
//   i_req     in  N_REQ  request vector
//   i_rr_ptr  in  ID_W   index with highest priority this cycle
//   o_grant   out N_REQ  one-hot grant (all zero when no request)
//   o_id      out ID_W   binary index of the granted requester
//   o_any     out 1      at least one request present
// -----------------------------------------------------------------------------
module booth_rr_arbiter
  import booth_mult_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_id,
  output logic             o_any
);

  always_comb begin
    int w_idx;
    w_idx   = 0;
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(i_rr_ptr) + k) % N_REQ;
      // o_any doubles as the "already found" flag so only the first hit wins.
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_id           = ID_W'(w_idx);
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_sched.sv
// -----------------------------------------------------------------------------
// booth_mult_sched
// Shares one iterative radix-2 Booth multiplier core among N_REQ requesters.
// Picks a requester round-robin, hands its operands to the core, pulses
// mul_load once, then mul_step for exactly ITERS cycles, captures the low
// WIDTH bits of the product and returns them tagged with the requester ID.
// Ports:
//   clock, reset          system clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_op_a/req_op_b     packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready result handshake
//   resp_id/resp_data     owner of the result and the truncated signed product
//   busy                  high whenever the controller is not idle
//   mul_load/mul_step     core sequencing pulses
//   mul_op_a/mul_op_b     operands held for the core during a multiply
//   mul_result            core product, valid after ITERS steps
// -----------------------------------------------------------------------------
module booth_mult_sched
  import booth_mult_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITERS = ITERS_DEF,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_op_a,
  input  logic [N_REQ*WIDTH-1:0] req_op_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   busy,
  output logic                   mul_load,
  output logic                   mul_step,
  output logic [WIDTH-1:0]       mul_op_a,
  output logic [WIDTH-1:0]       mul_op_b,
  input  logic [WIDTH-1:0]       mul_result
);

  // One spare count value so ITERS itself is representable.
  localparam int CNT_W = $clog2(ITERS + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_gnt_id;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_any;
  logic             w_accept;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  booth_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_id     (w_gnt_id),
    .o_any    (w_any)
  );

  // Ready is only offered in IDLE, so the grant itself is the handshake.
  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign w_accept  = (r_state == ST_IDLE) && w_any;
  assign w_op_a    = req_op_a[int'(w_gnt_id)*WIDTH +: WIDTH];
  assign w_op_b    = req_op_b[int'(w_gnt_id)*WIDTH +: WIDTH];

  // All outputs are registered and updated on the transition into the state
  // that owns them, so they line up with r_state without decode glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      busy       <= 1'b0;
      mul_load   <= 1'b0;
      mul_step   <= 1'b0;
      mul_op_a   <= '0;
      mul_op_b   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gnt_id <= w_gnt_id;
            mul_op_a <= w_op_a;
            mul_op_b <= w_op_b;
            mul_load <= 1'b1;
            busy     <= 1'b1;
            r_state  <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          mul_load <= 1'b0;
          mul_step <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_RUN;
        end

        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Count reaches ITERS-1 on the last step cycle; drop the step
          // strobe here so the core sees exactly ITERS pulses.
          if (r_cnt == CNT_W'(ITERS - 1)) begin
            mul_step <= 1'b0;
            r_state  <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          resp_data  <= mul_result;
          resp_id    <= r_gnt_id;
          resp_valid <= 1'b1;
          r_state    <= ST_RESP;
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            r_rr_ptr   <= next_ptr(r_gnt_id);
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          mul_load   <= 1'b0;
          mul_step   <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_sched.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_sched
// Directed bench for booth_mult_sched with a behavioural radix-2 Booth core
// attached to the mul_* ports. Expected products are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_booth_mult_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op_a;
  logic [N*W-1:0] req_op_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           busy;
  logic           mul_load;
  logic           mul_step;
  logic [W-1:0]   mul_op_a;
  logic [W-1:0]   mul_op_b;
  logic [W-1:0]   mul_result;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int step_cnt = 0;

  always #5 clock = ~clock;

  booth_mult_sched dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .mul_load   (mul_load),
    .mul_step   (mul_step),
    .mul_op_a   (mul_op_a),
    .mul_op_b   (mul_op_b),
    .mul_result (mul_result)
  );

  // Behavioural Booth core: {acc, q, q_-1}, acc one bit wider to avoid overflow.
  logic signed [W:0] m_acc = '0;
  logic [W-1:0]      m_q   = '0;
  logic              m_qm1 = 1'b0;
  logic [W:0]        m_sum;

  always_comb begin
    m_sum = m_acc;
    if (m_q[0] && !m_qm1)      m_sum = m_acc - {mul_op_a[W-1], mul_op_a};
    else if (!m_q[0] && m_qm1) m_sum = m_acc + {mul_op_a[W-1], mul_op_a};
  end

  always @(posedge clock) begin
    if (mul_load) begin
      m_acc <= '0;
      m_q   <= mul_op_b;
      m_qm1 <= 1'b0;
    end else if (mul_step) begin
      m_acc <= {m_sum[W], m_sum[W:1]};
      m_q   <= {m_sum[0], m_q[W-1:1]};
      m_qm1 <= m_q[0];
    end
  end

  assign mul_result = m_q;

  always @(posedge clock) begin
    cyc_no <= cyc_no + 1;
    if (mul_step) step_cnt <= step_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op_a[idx*W +: W] = a;
    req_op_b[idx*W +: W] = b;
  endtask

  task automatic wait_ready(input int idx, input string tag);
    for (int k = 0; k < 60; k++) begin
      if (req_ready[idx]) break;
      @(negedge clock);
    end
    if (!req_ready[idx]) chk({tag, "_ready_timeout"}, 32'(req_ready[idx]), 1);
  endtask

  task automatic wait_resp(input string tag, output int t);
    t = -1;
    for (int k = 0; k < 80; k++) begin
      if (resp_valid) begin
        t = cyc_no;
        break;
      end
      @(negedge clock);
    end
    if (t < 0) chk({tag, "_resp_timeout"}, 32'(resp_valid), 1);
  endtask

  // One complete transaction from requester idx with full timing checks.
  task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string tag);
    int t0, t1, s0;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    set_ops(idx, a, b);
    #1;
    wait_ready(idx, tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << idx));
    t0 = cyc_no;
    s0 = step_cnt;
    @(negedge clock);
    req_valid = '0;
    set_ops(idx, 16'hDEAD, 16'hBEEF);
    chk({tag, "_load"}, 32'(mul_load), 1);
    chk({tag, "_opa"}, 32'(mul_op_a), 32'(a));
    chk({tag, "_opb"}, 32'(mul_op_b), 32'(b));
    wait_resp(tag, t1);
    chk({tag, "_latency"}, 32'(t1 - t0), 19);
    chk({tag, "_steps"}, 32'(step_cnt - s0), 16);
    chk({tag, "_data"}, 32'(resp_data), 32'(exp));
    chk({tag, "_id"}, 32'(resp_id), 32'(idx));
    resp_ready = 1'b1;
    @(negedge clock);
    chk({tag, "_drop"}, 32'(resp_valid), 0);
    resp_ready = 1'b0;
  endtask

  logic [W-1:0] fair_exp [N];
  int           fair_ord [6];

  initial begin
    int bad, t, prev, t0, s0;
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_op_a   = '0;
    req_op_b   = '0;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(mul_load), 0);
    chk("rst_step", 32'(mul_step), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_opa", 32'(mul_op_a), 0);
    chk("rst_ready", 32'(req_ready), 0);
    reset = 1'b0;

    // Idle with no requests
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (busy || mul_load || mul_step || resp_valid) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);

    // Single request and edge operands
    run_one(0, 16'h0003, 16'hFFFE, 16'hFFFA, "single");
    run_one(2, 16'h7FFF, 16'h0002, 16'hFFFE, "edge_max");
    run_one(2, 16'h8000, 16'hFFFF, 16'h8000, "edge_min");
    run_one(2, 16'h0000, 16'h1234, 16'h0000, "edge_zero");

    // Fairness: everyone requests continuously
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    set_ops(0, 16'h0005, 16'h0007); fair_exp[0] = 16'h0023;
    set_ops(1, 16'hFFFD, 16'h0004); fair_exp[1] = 16'hFFF4;
    set_ops(2, 16'h0010, 16'h0011); fair_exp[2] = 16'h0110;
    set_ops(3, 16'h1234, 16'h0010); fair_exp[3] = 16'h2340;
    fair_ord = '{0, 1, 2, 3, 0, 1};
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    #1;
    chk("fair_first_grant", 32'(req_ready), 32'h1);
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_resp("fair", t);
      chk($sformatf("fair_id%0d", k), 32'(resp_id), 32'(fair_ord[k]));
      chk($sformatf("fair_data%0d", k), 32'(resp_data), 32'(fair_exp[fair_ord[k]]));
      if (k > 0) chk($sformatf("fair_gap%0d", k), 32'(t - prev), 20);
      prev = t;
      @(negedge clock);
    end
    req_valid  = '0;
    resp_ready = 1'b0;

    // Backpressure: rr_ptr now points at 2, only requester 3 asks first
    req_valid[3] = 1'b1;
    set_ops(3, 16'h0006, 16'h0007);
    #1;
    wait_ready(3, "bp");
    @(negedge clock);
    req_valid = 4'b0010;
    set_ops(1, 16'h0002, 16'h0009);
    wait_resp("bp", t);
    chk("bp_data", 32'(resp_data), 32'h002A);
    chk("bp_id", 32'(resp_id), 3);
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_data !== 16'h002A || resp_id !== 2'd3 || req_ready !== 4'b0)
        bad++;
    end
    chk("bp_stable", 32'(bad), 0);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("bp_released", 32'(resp_valid), 0);
    chk("bp_next_ready", 32'(req_ready), 32'h2);
    @(negedge clock);
    req_valid = '0;
    chk("bp_next_load", 32'(mul_load), 1);
    wait_resp("bp2", t);
    chk("bp2_data", 32'(resp_data), 32'h0012);
    chk("bp2_id", 32'(resp_id), 1);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;

    // Reset in the middle of RUN (rr_ptr is 2 here)
    req_valid[0] = 1'b1;
    set_ops(0, 16'h0003, 16'h0005);
    #1;
    wait_ready(0, "mr");
    @(negedge clock);
    req_valid = '0;
    repeat (8) @(negedge clock);
    chk("mr_running", 32'(mul_step), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_step", 32'(mul_step), 0);
    chk("mr_load", 32'(mul_load), 0);
    chk("mr_resp_valid", 32'(resp_valid), 0);
    chk("mr_resp_data", 32'(resp_data), 0);
    chk("mr_resp_id", 32'(resp_id), 0);
    chk("mr_opa", 32'(mul_op_a), 0);
    chk("mr_opb", 32'(mul_op_b), 0);
    reset = 1'b0;
    s0  = step_cnt;
    bad = 0;
    repeat (30) begin
      @(negedge clock);
      if (resp_valid || busy) bad++;
    end
    chk("mr_no_resp", 32'(bad), 0);
    chk("mr_no_steps", 32'(step_cnt - s0), 0);
    // With rr_ptr back at 0, requester 1 beats requester 3.
    set_ops(1, 16'hFFFF, 16'hFFFF);
    set_ops(3, 16'h0004, 16'h0004);
    req_valid = 4'b1010;
    #1;
    chk("mr_ptr_grant", 32'(req_ready), 32'h2);
    t0 = cyc_no;
    @(negedge clock);
    req_valid = '0;
    wait_resp("mr_new", t);
    chk("mr_new_latency", 32'(t - t0), 19);
    chk("mr_new_data", 32'(resp_data), 32'h0001);
    chk("mr_new_id", 32'(resp_id), 1);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
